fdiv_cal_ctrl: RTL
==================

FDIV_CAL_CTRL -- requirements
Module: fdiv_cal_ctrl

Interface
REQ-001 Parameter WINDOW, default 1024: measurement window length in Clk cycles (range 16..4095).
REQ-002 Parameter SETTLE, default 64: wait in Clk cycles after every Tune change before measuring (range 1..255).
REQ-003 Parameter TOL, default 8: maximum |Count-Target| for which Locked is asserted.
REQ-004 Parameter CAL_SEL, default 4'b0101: divider tap forced onto Fsel during calibration (div-by-32 path).
REQ-005 Clk  input  1  system clock; all logic on its rising edge.
REQ-006 Resetn  input  1  reset, asynchronous, active-low.
REQ-007 Start  input  1  single-cycle calibration request.
REQ-008 Fpfd  input  1  divided VCO clock from the divider, asynchronous to Clk, toggles at most Clk/4.
REQ-009 Target  input  12  required Fpfd rising-edge count per window.
REQ-010 FselReq  input  4  user divider-tap selection.
REQ-011 Tune  output  4  VCO coarse tune code; higher code means higher frequency.
REQ-012 Fsel  output  4  registered divider tap selection.
REQ-013 Count  output  12  last completed window edge count.
REQ-014 Busy  output  1  calibration in progress.
REQ-015 Done  output  1  one-cycle pulse at calibration end.
REQ-016 Locked  output  1  final measurement within TOL.

Function
REQ-017 Fpfd SHALL pass a 2-flop synchronizer then a rising-edge detector; each detected edge counts once.
REQ-018 FSM states SHALL be IDLE, SETTLE, MEASURE, DECIDE, VERIFY_SETTLE, VERIFY, DONE.
REQ-019 IDLE: Start=1 -> SETTLE next cycle; Tune<=4'b1000, bit index<=3, Busy<=1, Locked<=0.
REQ-020 Start while Busy=1 SHALL be ignored.
REQ-021 SETTLE SHALL last exactly SETTLE cycles, then enter MEASURE with the window counter and edge counter cleared.
REQ-022 MEASURE SHALL last exactly WINDOW cycles; the edge counter SHALL saturate at 12'hFFF, never wrap.
REQ-023 At window end Count SHALL load the edge count and the FSM SHALL enter DECIDE (or DONE when coming from VERIFY).
REQ-024 DECIDE (one cycle): Count < Target keeps Tune[idx], otherwise clears it; if idx>0 set Tune[idx-1], idx-=1, go SETTLE; if idx=0 go VERIFY_SETTLE.
REQ-025 VERIFY_SETTLE/VERIFY SHALL repeat SETTLE/MEASURE on the final Tune without changing it.
REQ-026 DONE (one cycle): Done=1, Busy<=0, Locked<=(|Count-Target|<=TOL) using 13-bit unsigned difference; then IDLE.
REQ-027 Tune, Count, Locked SHALL hold their values in IDLE until the next Start.
REQ-028 Fsel SHALL equal CAL_SEL while Busy=1; in IDLE Fsel SHALL load FselReq every cycle.
REQ-029 Total calibration latency, Start to Done, SHALL be 5*(SETTLE+WINDOW)+4 cycles plus 1 for IDLE exit.
REQ-030 Target=0 SHALL yield Tune=0; Target above all counts SHALL yield Tune=4'hF.

Reset
REQ-031 Resetn=0 SHALL immediately force state IDLE, Tune=4'b1000, Fsel=CAL_SEL, Count=0, Busy=0, Done=0, Locked=0, synchronizer and counters=0.
REQ-032 Reset asserted mid-calibration SHALL abort without a Done pulse; first post-reset cycle Fsel loads FselReq.

Verification
REQ-033 Bench VCO model gives 16*Tune+4 edges/window, Target=120, TOL=8: Start -> Tune sequence 8,4,6,7, final Tune=7, Count=116, Locked=1, Done one cycle.
REQ-034 Same model, Target=125, TOL=2: -> Tune=7, Count=116, Locked=0.
REQ-035 Target=0 -> Tune=0, Count=4; Target=4095 -> Tune=15, Count=244.
REQ-036 Start pulsed again during MEASURE -> ignored, Done exactly once at 5*(SETTLE+WINDOW)+5 cycles after first Start.
REQ-037 Resetn pulsed low during second MEASURE -> Busy=0, Done never pulses, Tune=8, Fsel follows FselReq=4'b0011 next cycle.
REQ-038 Fpfd held at Clk/4 toggle rate with WINDOW=4095 -> edge count 1023, no loss or double count.

Source files
------------

// File: rtl/fdiv_cal_ctrl.sv
// fdiv_cal_ctrl: binary-search VCO coarse-tune calibration by counting Fpfd edges per window
module fdiv_cal_ctrl #(
    parameter int         WINDOW  = 1024,
    parameter int         SETTLE  = 64,
    parameter int         TOL     = 8,
    parameter logic [3:0] CAL_SEL = 4'b0101
) (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        Fpfd,
    input  logic [11:0] Target,
    input  logic [3:0]  FselReq,
    output logic [3:0]  Tune,
    output logic [3:0]  Fsel,
    output logic [11:0] Count,
    output logic        Busy,
    output logic        Done,
    output logic        Locked
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_DECIDE  = 3'd3;
    localparam logic [2:0] ST_VSETTLE = 3'd4;
    localparam logic [2:0] ST_VERIFY  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    logic [2:0]  state;
    logic [1:0]  idx;
    logic [11:0] cnt, edges, edges_inc;
    logic [2:0]  sync;
    logic        rise, settle_end, win_end;
    logic [12:0] diff, mag;

    // sync[1:0] is the synchronizer, sync[2] holds the previous level for edge detection
    assign rise       = sync[1] & ~sync[2];
    assign settle_end = cnt == 12'(SETTLE - 1);
    assign win_end    = cnt == 12'(WINDOW - 1);
    assign edges_inc  = (rise && edges != 12'hFFF) ? edges + 12'd1 : edges;
    assign diff       = {1'b0, Count} - {1'b0, Target};
    assign mag        = diff[12] ? -diff : diff;
    assign Done       = state == ST_DONE;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= ST_IDLE;
            Tune   <= 4'b1000;
            Fsel   <= CAL_SEL;
            Count  <= '0;
            Busy   <= 1'b0;
            Locked <= 1'b0;
            idx    <= 2'd3;
            cnt    <= '0;
            edges  <= '0;
            sync   <= '0;
        end else begin
            sync  <= {sync[1:0], Fpfd};
            Fsel  <= ((state == ST_IDLE && !Start) || state == ST_DONE) ? FselReq : CAL_SEL;
            cnt   <= cnt + 12'd1;
            edges <= edges_inc;
            case (state)
                ST_IDLE: if (Start) begin
                    state  <= ST_SETTLE;
                    Tune   <= 4'b1000;
                    idx    <= 2'd3;
                    Busy   <= 1'b1;
                    Locked <= 1'b0;
                    cnt    <= '0;
                end
                ST_SETTLE, ST_VSETTLE: if (settle_end) begin
                    state <= state == ST_SETTLE ? ST_MEASURE : ST_VERIFY;
                    cnt   <= '0;
                    edges <= '0;
                end
                ST_MEASURE, ST_VERIFY: if (win_end) begin
                    Count <= edges_inc;
                    state <= state == ST_MEASURE ? ST_DECIDE : ST_DONE;
                end
                ST_DECIDE: begin
                    Tune[idx] <= Count < Target;
                    cnt       <= '0;
                    if (idx != 2'd0) begin
                        Tune[idx - 2'd1] <= 1'b1;
                        idx              <= idx - 2'd1;
                        state            <= ST_SETTLE;
                    end else begin
                        state <= ST_VSETTLE;
                    end
                end
                ST_DONE: begin
                    Busy   <= 1'b0;
                    Locked <= mag <= 13'(TOL);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
